// File: rtl/spi_frame_checker.sv
// Rhythm frame aligner: hunts the 64-bit magic, checks timestamps and
// forwards whole accepted frames to the data FIFO through a 3-word delay.
// Ports:
//   dataclk, reset_n        - clock, async active-low reset
//   din, din_valid          - words from the SPI engine
//   fifo_full               - downstream FIFO full flag
//   dout, dout_wen          - FIFO write port
//   in_sync, overflow       - frame lock, sticky loss flag
//   frame_count, *_count    - frame / error / drop statistics
module spi_frame_checker #(
  parameter int FRAME_WORDS = 198
) (
  input  logic        dataclk,
  input  logic        reset_n,
  input  logic [15:0] din,
  input  logic        din_valid,
  input  logic        fifo_full,
  output logic [15:0] dout,
  output logic        dout_wen,
  output logic        in_sync,
  output logic        overflow,
  output logic [31:0] frame_count,
  output logic [15:0] hdr_err_count,
  output logic [15:0] ts_err_count,
  output logic [15:0] drop_count
);

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] BODY = 2'd2;

  localparam logic [15:0] LAST = 16'(FRAME_WORDS - 1);

  function automatic logic [15:0] magic(
    input logic [1:0] i
  );
    logic [15:0] m;
    unique case (i)
      2'd0: m = 16'h1942;
      2'd1: m = 16'h2702;
      2'd2: m = 16'h1999;
      default: m = 16'hC691;
    endcase
    return m;
  endfunction

  function automatic logic [15:0] sat(
    input logic [15:0] c
  );
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [1:0]  state;
  logic [15:0] idx;
  logic        accept;
  logic        have_prev;
  logic [31:0] prev_ts;
  logic [15:0] ts_lo;
  logic [15:0] q0, q1, q2;
  logic [2:0]  keep;

  logic        hdr_hit;
  logic        acc_now;
  logic        k_in;
  logic [2:0]  kq;
  logic [31:0] ts;

  assign in_sync = (state == BODY);
  assign hdr_hit = (din == magic(idx[1:0]));
  assign ts      = {din, ts_lo};

  // Accepted last magic word: the three held header words are
  // marked retroactively, including the one leaving this cycle.
  // Header words otherwise enter unmarked, so a broken header
  // never has anything marked to write.
  always_comb begin
    acc_now = 1'b0;
    if (din_valid && state == HDR &&
        hdr_hit && idx == 16'd3)
      acc_now = ~fifo_full;
    kq   = acc_now ? 3'b111 : keep;
    k_in = acc_now | ((state == BODY) & accept);
  end

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HUNT;
      idx           <= '0;
      accept        <= 1'b0;
      have_prev     <= 1'b0;
      prev_ts       <= '0;
      ts_lo         <= '0;
      q0            <= '0;
      q1            <= '0;
      q2            <= '0;
      keep          <= '0;
      dout          <= '0;
      dout_wen      <= 1'b0;
      overflow      <= 1'b0;
      frame_count   <= '0;
      hdr_err_count <= '0;
      ts_err_count  <= '0;
      drop_count    <= '0;
    end else begin
      dout_wen <= 1'b0;
      if (din_valid) begin
        dout     <= q2;
        dout_wen <= kq[2] & ~overflow & ~fifo_full;
        if (kq[2] & fifo_full)
          overflow <= 1'b1;
        q2   <= q1;
        q1   <= q0;
        q0   <= din;
        keep <= {kq[1:0], k_in};

        unique case (1'b1)
          (state == HDR): begin
            if (!hdr_hit) begin
              state         <= HUNT;
              idx           <= '0;
              hdr_err_count <= sat(hdr_err_count);
            end else if (idx == 16'd3) begin
              state  <= BODY;
              idx    <= 16'd4;
              accept <= ~fifo_full;
            end else begin
              idx <= idx + 16'd1;
            end
          end
          (state == BODY): begin
            idx <= idx + 16'd1;
            if (idx == 16'd4)
              ts_lo <= din;
            if (idx == 16'd5) begin
              if (have_prev &&
                  ts != prev_ts + 32'd1)
                ts_err_count <= sat(ts_err_count);
              prev_ts   <= ts;
              have_prev <= 1'b1;
            end
            if (idx == LAST) begin
              state <= HUNT;
              idx   <= '0;
              if (accept)
                frame_count <= frame_count + 32'd1;
              else
                drop_count <= sat(drop_count);
            end
          end
          default: begin
            state <= HUNT;
            idx   <= '0;
            if (din == magic(2'd0)) begin
              state <= HDR;
              idx   <= 16'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_checker.sv
// Scoreboard bench for spi_frame_checker: directed frames, a monitor
// pops expected FIFO writes whenever dout_wen is seen.
module tb_spi_frame_checker;

  localparam int FW = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic [15:0] dout;
  logic        dout_wen;
  logic        in_sync;
  logic        overflow;
  logic [31:0] frame_count;
  logic [15:0] hdr_err_count;
  logic [15:0] ts_err_count;
  logic [15:0] drop_count;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_frame_checker #(.FRAME_WORDS(FW)) dut (
    .dataclk      (clk),
    .reset_n      (reset_n),
    .din          (din),
    .din_valid    (din_valid),
    .fifo_full    (fifo_full),
    .dout         (dout),
    .dout_wen     (dout_wen),
    .in_sync      (in_sync),
    .overflow     (overflow),
    .frame_count  (frame_count),
    .hdr_err_count(hdr_err_count),
    .ts_err_count (ts_err_count),
    .drop_count   (drop_count)
  );

  always @(negedge clk) begin
    if (reset_n && dout_wen === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write: got %h, none expected", dout);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          n_fail++;
          $display("FAIL write: got %h expected %h", dout, e);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(
    int i, logic [31:0] ts, int seed
  );
    logic [15:0] m [4];
    m[0] = 16'h1942; m[1] = 16'h2702;
    m[2] = 16'h1999; m[3] = 16'hC691;
    if (i < 4) return m[i];
    if (i == 4) return ts[15:0];
    if (i == 5) return ts[31:16];
    return 16'((seed << 8) ^ i ^ 16'hA5A5);
  endfunction

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [15:0] w, logic ff);
    din = w;
    din_valid = 1'b1;
    fifo_full = ff;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic send_frame(logic [31:0] ts, int seed,
                            int nw, int keep_n,
                            int ff_idx, bit first);
    logic [15:0] w;
    for (int i = 0; i < nw; i++) begin
      w = word_of(i, ts, seed);
      if (i < keep_n) exp_q.push_back(w);
      send(w, i == ff_idx);
      if (first && i == 2)
        chk("no_early_wen", dout_wen, 0);
      if (first && i == 3) begin
        chk("first_wen", dout_wen, 1);
        chk("first_dout", dout, 16'h1942);
      end
      if (i == 3) chk("in_sync_on", in_sync, 1);
      if (i == FW - 1) chk("in_sync_off", in_sync, 0);
      if (i % 9 == 4) idle(2);
    end
  endtask

  task automatic flush_end(string tag);
    for (int i = 0; i < 3; i++) send(16'h0000, 1'b0);
    idle(2);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    din = '0;
    din_valid = 1'b0;
    fifo_full = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    do_reset();
    chk("rst_dout", dout, 0);
    chk("rst_wen", dout_wen, 0);
    chk("rst_sync", in_sync, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_hdr", hdr_err_count, 0);
    chk("rst_ts", ts_err_count, 0);
    chk("rst_drop", drop_count, 0);

    // back-to-back frames
    send_frame(100, 1, FW, FW, -1, 1);
    send_frame(101, 2, FW, FW, -1, 0);
    flush_end("p1");
    chk("p1_frames", frame_count, 2);
    chk("p1_ts", ts_err_count, 0);
    chk("p1_hdr", hdr_err_count, 0);
    chk("p1_drop", drop_count, 0);

    // broken header then good frame
    do_reset();
    send(16'h1942, 0);
    send(16'h2702, 0);
    send(16'h0000, 0);
    send_frame(50, 3, FW, FW, -1, 1);
    flush_end("p2");
    chk("p2_hdr", hdr_err_count, 1);
    chk("p2_frames", frame_count, 1);

    // timestamp gap
    do_reset();
    send_frame(5, 4, FW, FW, -1, 1);
    send_frame(6, 5, FW, FW, -1, 0);
    send_frame(9, 6, FW, FW, -1, 0);
    flush_end("p3");
    chk("p3_ts", ts_err_count, 1);
    chk("p3_frames", frame_count, 3);

    // dropped middle frame
    do_reset();
    send_frame(1, 7, FW, FW, -1, 1);
    send_frame(2, 8, FW, 0, 3, 0);
    send_frame(3, 9, FW, FW, -1, 0);
    flush_end("p4");
    chk("p4_drop", drop_count, 1);
    chk("p4_frames", frame_count, 2);
    chk("p4_ovf", overflow, 0);

    // overflow mid-frame
    do_reset();
    send_frame(10, 10, FW, 17, 20, 1);
    chk("p5_ovf_set", overflow, 1);
    send_frame(11, 11, FW, 0, -1, 0);
    flush_end("p5");
    chk("p5_ovf", overflow, 1);
    chk("p5_frames", frame_count, 2);

    // reset in the middle of a body
    do_reset();
    send_frame(1000, 12, FW, FW, -1, 1);
    send_frame(1001, 13, 11, 8, -1, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_wen", dout_wen, 0);
    chk("mid_rst_sync", in_sync, 0);
    chk("mid_rst_frames", frame_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    send_frame(7, 14, FW, FW, -1, 1);
    flush_end("p6");
    chk("p6_frames", frame_count, 1);
    chk("p6_ts", ts_err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
